face_result_collector: RTL
==========================

// Module: face_result_collector
// PURPOSE
//  Sits between the face detection engine and the result writer. Gathers the candidate hits
//  streamed out during one frame scan and keeps the highest-scoring one. At end of frame it
//  clips that box to the image bounds, then runs one start/done transaction with the writer.
//  If the frame has no hits, the writer still runs, with length 0: plain image copy, no box.
// PARAMETERS
//  WIDTH_POSI   8    width of x/y/length fields
//  WIDTH_SCORE  12   width of classifier score (unsigned)
//  IMG_W        160  image width in pixels
//  IMG_H        120  image height in pixels
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            synchronous, active-high reset
//  frame_start  in   1            pulse: engine begins scanning a new frame
//  hit_valid    in   1            candidate window accepted by classifier this cycle
//  hit_x        in   WIDTH_POSI   candidate top-left x
//  hit_y        in   WIDTH_POSI   candidate top-left y
//  hit_len      in   WIDTH_POSI   candidate side length
//  hit_score    in   WIDTH_SCORE  candidate score
//  frame_end    in   1            pulse: engine finished scanning the frame
//  ready        out  1            high in IDLE/COLLECT (frame_end will be accepted)
//  busy         out  1            high in ISSUE/WAIT
//  wr_start     out  1            one-cycle start pulse to the result writer
//  wr_done      in   1            result writer completion (sampled as level)
//  wr_xpos      out  WIDTH_POSI   box x to writer
//  wr_ypos      out  WIDTH_POSI   box y to writer
//  wr_len       out  WIDTH_POSI   clipped box length to writer (0 = no box)
//  face_found   out  1            the last issued frame had at least one valid hit
//  hit_count    out  8            valid hits this frame, saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are registered and reset to 0, except ready=1.
//  States and transitions:
//   IDLE    frame_start -> COLLECT. On entry, clear best_score/best box/hit_count/found.
//   COLLECT A hit is valid when hit_valid && hit_len!=0 && hit_x<IMG_W && hit_y<IMG_H.
//           Invalid hits are dropped and not counted.
//           Valid hit: hit_count++ (saturating). If !found or hit_score>best_score
//           (strictly greater), latch it as best. Ties keep the earlier hit.
//           frame_end -> ISSUE. frame_start -> clear and stay in COLLECT.
//   ISSUE   one cycle: wr_start=1, then -> WAIT.
//   WAIT    wr_done=1 -> IDLE, or -> COLLECT (cleared) if pending_start is set.
//  Latency: frame_end sampled in cycle N -> wr_start high in cycle N+1 only.
//  Stability: wr_xpos/ypos/len/face_found are valid in N+1 and held until wr_done is accepted.
//  Clipping (in ISSUE):
//   wr_len = min(best_len, IMG_W-best_x, IMG_H-best_y), computed one bit wider.
//   No face: wr_xpos=wr_ypos=wr_len=0, face_found=0.
//  Simultaneous events:
//   hit_valid+frame_end in COLLECT: the hit is evaluated before the frame closes.
//   frame_start+frame_end in COLLECT: frame_start wins (restart), frame_end is dropped.
//   frame_start+hit_valid: clear, then the hit is the first of the new frame.
//  In ISSUE/WAIT:
//   hit_valid and frame_end are ignored.
//   frame_start sets pending_start; a second one is absorbed.
//  wr_done:
//   Ignored in IDLE/COLLECT/ISSUE; only honoured in WAIT, and earliest in cycle N+2.
//   wr_done held high for several cycles triggers only one transaction end.
//  Reset mid-transaction: rst in any state -> IDLE next cycle.
//   wr_start is never asserted in the cycle after rst. pending_start is cleared.
//  No frame_end ever arriving is not an error; the block stays in COLLECT.
// STRUCTURE
//  Shared header (face_detect_defs.vh):
//   WIDTH_POSI, WIDTH_SCORE, IMG_W, IMG_H, state encodings.
//   S_IDLE=0, S_COLLECT=1, S_ISSUE=2, S_WAIT=3 (2 bits, matching the writer's state width).
//  One combinational sub-module, box_clipper: (x,y,len) -> clipped len.
//   Reused later by the marker.
//  The rest is a single FSM plus best-hit registers in this file.
// TESTING
//  T1 one frame:
//   hits (10,20,30,s=5), (40,50,24,s=9), (60,10,16,s=9), then frame_end.
//   -> wr_start 1 cycle later, wr=(40,50,24), hit_count=3, face_found=1.
//  T2 empty frame: frame_start, frame_end.
//   -> wr_start, wr_len=0, face_found=0.
//   wr_done at +3 -> IDLE, ready=1.
//  T3 clip:
//   hit (150,100,40), IMG 160x120 -> wr_len=10.
//   hit x=160 is dropped, hit_count unchanged.
//  T4 simultaneous:
//   hit (5,5,8,s=1) and frame_end in the same cycle -> wr=(5,5,8).
//   frame_start with frame_end -> no wr_start, stays in COLLECT.
//  T5 pending: frame_start during WAIT, then wr_done.
//   -> COLLECT with hit_count=0, no extra wr_start.
//   wr_done held 4 cycles -> one completion only.
//  T6 reset mid-WAIT:
//   rst=1 for 1 cycle -> all outputs 0, ready=1, state IDLE.
//   A later wr_done is ignored.

Source files
------------

// File: rtl/face_result_collector_pkg.sv
// rtl/face_result_collector_pkg.sv - shared widths, image bounds and FSM encoding
package face_result_collector_pkg;

  localparam int DEF_WIDTH_POSI  = 8;
  localparam int DEF_WIDTH_SCORE = 12;
  localparam int DEF_IMG_W       = 160;
  localparam int DEF_IMG_H       = 120;

  localparam logic [7:0] HIT_COUNT_MAX = 8'hFF;

  // 2-bit encoding shared with the result writer's state width
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ISSUE   = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

endpackage

// File: rtl/face_result_collector_box_clipper.sv
// rtl/face_result_collector_box_clipper.sv - clips a square box length to the image bounds
module box_clipper #(
  parameter int WIDTH_POSI = 8,
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120
) (
  input  logic [WIDTH_POSI-1:0] x_i,
  input  logic [WIDTH_POSI-1:0] y_i,
  input  logic [WIDTH_POSI-1:0] len_i,
  output logic [WIDTH_POSI-1:0] len_o
);

  localparam logic [WIDTH_POSI:0] IMG_W_V = (WIDTH_POSI+1)'(IMG_W);
  localparam logic [WIDTH_POSI:0] IMG_H_V = (WIDTH_POSI+1)'(IMG_H);

  logic [WIDTH_POSI:0] len_w;
  logic [WIDTH_POSI:0] rem_x;
  logic [WIDTH_POSI:0] rem_y;
  logic [WIDTH_POSI:0] min_xl;

  // One bit wider so IMG_W - x never wraps for in-bounds x
  always_comb begin
    len_w  = {1'b0, len_i};
    rem_x  = IMG_W_V - {1'b0, x_i};
    rem_y  = IMG_H_V - {1'b0, y_i};
    min_xl = (rem_x < len_w) ? rem_x : len_w;
    len_o  = (rem_y < min_xl) ? rem_y[WIDTH_POSI-1:0] : min_xl[WIDTH_POSI-1:0];
  end

endmodule

// File: rtl/face_result_collector.sv
// rtl/face_result_collector.sv - keeps the best face hit of a frame and hands it to the writer
module face_result_collector
  import face_result_collector_pkg::*;
#(
  parameter int WIDTH_POSI  = DEF_WIDTH_POSI,
  parameter int WIDTH_SCORE = DEF_WIDTH_SCORE,
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   hit_valid,
  input  logic [WIDTH_POSI-1:0]  hit_x,
  input  logic [WIDTH_POSI-1:0]  hit_y,
  input  logic [WIDTH_POSI-1:0]  hit_len,
  input  logic [WIDTH_SCORE-1:0] hit_score,
  input  logic                   frame_end,
  output logic                   ready,
  output logic                   busy,
  output logic                   wr_start,
  input  logic                   wr_done,
  output logic [WIDTH_POSI-1:0]  wr_xpos,
  output logic [WIDTH_POSI-1:0]  wr_ypos,
  output logic [WIDTH_POSI-1:0]  wr_len,
  output logic                   face_found,
  output logic [7:0]             hit_count
);

  localparam logic [WIDTH_POSI:0] IMG_W_V = (WIDTH_POSI+1)'(IMG_W);
  localparam logic [WIDTH_POSI:0] IMG_H_V = (WIDTH_POSI+1)'(IMG_H);

  state_t                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic                   found_q, found_d;
  logic [WIDTH_SCORE-1:0] best_score_q, best_score_d;
  logic [WIDTH_POSI-1:0]  best_x_q, best_x_d;
  logic [WIDTH_POSI-1:0]  best_y_q, best_y_d;
  logic [WIDTH_POSI-1:0]  best_len_q, best_len_d;
  logic [7:0]             count_q, count_d;

  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   wr_start_q, wr_start_d;
  logic [WIDTH_POSI-1:0]  wr_xpos_q, wr_xpos_d;
  logic [WIDTH_POSI-1:0]  wr_ypos_q, wr_ypos_d;
  logic [WIDTH_POSI-1:0]  wr_len_q, wr_len_d;
  logic                   face_found_q, face_found_d;

  logic                   hit_ok;
  logic                   clear;
  logic                   take_hit;
  logic [WIDTH_POSI-1:0]  clip_len;

  assign hit_ok = hit_valid && (hit_len != '0) &&
                  ({1'b0, hit_x} < IMG_W_V) && ({1'b0, hit_y} < IMG_H_V);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    found_d      = found_q;
    best_score_d = best_score_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_len_d   = best_len_q;
    count_d      = count_q;
    clear        = 1'b0;
    take_hit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d  = S_COLLECT;
          clear    = 1'b1;
          take_hit = 1'b1;
        end
      end
      S_COLLECT: begin
        take_hit = 1'b1;
        if (frame_start) begin
          clear = 1'b1;
        end else if (frame_end) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        if (frame_start) pending_d = 1'b1;
      end
      S_WAIT: begin
        if (wr_done) begin
          clear     = pending_q || frame_start;
          state_d   = clear ? S_COLLECT : S_IDLE;
          pending_d = 1'b0;
        end else if (frame_start) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      found_d      = 1'b0;
      best_score_d = '0;
      best_x_d     = '0;
      best_y_d     = '0;
      best_len_d   = '0;
      count_d      = '0;
    end

    // Applied after the clear so a restart hit becomes the first of the new frame
    if (take_hit && hit_ok) begin
      if (count_d != HIT_COUNT_MAX) count_d = count_d + 8'd1;
      if (!found_d || (hit_score > best_score_d)) begin
        best_score_d = hit_score;
        best_x_d     = hit_x;
        best_y_d     = hit_y;
        best_len_d   = hit_len;
      end
      found_d = 1'b1;
    end
  end

  box_clipper #(
    .WIDTH_POSI (WIDTH_POSI),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H)
  ) u_clipper (
    .x_i   (best_x_d),
    .y_i   (best_y_d),
    .len_i (best_len_d),
    .len_o (clip_len)
  );

  // Writer outputs load on entry to ISSUE and hold through WAIT
  always_comb begin
    wr_start_d   = 1'b0;
    wr_xpos_d    = wr_xpos_q;
    wr_ypos_d    = wr_ypos_q;
    wr_len_d     = wr_len_q;
    face_found_d = face_found_q;
    ready_d      = (state_d == S_IDLE) || (state_d == S_COLLECT);
    busy_d       = !ready_d;
    if (state_d == S_ISSUE) begin
      wr_start_d   = 1'b1;
      wr_xpos_d    = found_d ? best_x_d : '0;
      wr_ypos_d    = found_d ? best_y_d : '0;
      wr_len_d     = found_d ? clip_len : '0;
      face_found_d = found_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      found_q      <= 1'b0;
      best_score_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_len_q   <= '0;
      count_q      <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      wr_start_q   <= 1'b0;
      wr_xpos_q    <= '0;
      wr_ypos_q    <= '0;
      wr_len_q     <= '0;
      face_found_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      found_q      <= found_d;
      best_score_q <= best_score_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_len_q   <= best_len_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      wr_start_q   <= wr_start_d;
      wr_xpos_q    <= wr_xpos_d;
      wr_ypos_q    <= wr_ypos_d;
      wr_len_q     <= wr_len_d;
      face_found_q <= face_found_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign wr_start   = wr_start_q;
  assign wr_xpos    = wr_xpos_q;
  assign wr_ypos    = wr_ypos_q;
  assign wr_len     = wr_len_q;
  assign face_found = face_found_q;
  assign hit_count  = count_q;

endmodule
